// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: shared stall bus, multi-cycle op kinds and FSM encodings
package pipe_stall_ctrl_pkg;
  localparam int STALL_W = 6;
  localparam logic STOP = 1'b1;
  localparam logic NOT_STOP = 1'b0;
  typedef logic [STALL_W-1:0] stall_bus_t;
  typedef enum logic [1:0] {
    MC_NONE = 2'b00,
    MC_MADD = 2'b01,
    MC_DIV  = 2'b10,
    MC_RSVD = 2'b11
  } mc_kind_e;
  typedef enum logic [1:0] {
    MC_IDLE = 2'b00,
    MC_RUN  = 2'b01,
    MC_DONE = 2'b10
  } mc_state_e;
  localparam stall_bus_t STALL_EX   = {NOT_STOP, NOT_STOP, STOP, STOP, STOP, STOP};
  localparam stall_bus_t STALL_ID   = {NOT_STOP, NOT_STOP, NOT_STOP, STOP, STOP, STOP};
  localparam stall_bus_t STALL_IF   = {NOT_STOP, NOT_STOP, NOT_STOP, NOT_STOP, STOP, STOP};
  localparam stall_bus_t STALL_NONE = '0;
  function automatic logic mc_kind_valid(input logic [1:0] k);
    return k == MC_MADD || k == MC_DIV;
  endfunction
endpackage

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline stall vector builder and multi-cycle EX sequencer
import pipe_stall_ctrl_pkg::*;
module pipe_stall_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             ex_mc_req,
  input  logic [1:0]       ex_mc_kind,
  input  logic             ex_div_zero,
  input  logic             ex_mc_annul,
  output logic [5:0]       stall,
  output logic             mc_busy,
  output logic             mc_first,
  output logic [CNT_W-1:0] mc_cnt,
  output logic             mc_done,
  output logic             mc_div_zero
);
  mc_state_e state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic zf, zf_n;
  logic abort, start, last, ex_mc_stall;
  // a request dropped mid-divide is a protocol error and is handled as an annul
  assign abort = ex_mc_annul | (state == MC_RUN & ~ex_mc_req);
  assign start = state == MC_IDLE & ex_mc_req & mc_kind_valid(ex_mc_kind) & ~ex_mc_annul;
  assign last = cnt == CNT_W'(DIV_CYCLES - 1);
  assign ex_mc_stall = start | (state == MC_RUN & ~abort);
  assign mc_busy = ~rst & state != MC_IDLE;
  assign mc_first = ~rst & start & ex_mc_kind == MC_MADD;
  assign mc_done = ~rst & state == MC_DONE & ~ex_mc_annul;
  assign mc_div_zero = mc_done & zf;
  assign mc_cnt = rst ? '0 : cnt;
  // state, iteration counter and divide-by-zero flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MC_IDLE;
      cnt <= '0;
      zf <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      zf <= zf_n;
    end
  end
  // next state: annul wins, madd and div-by-zero finish after one pass, divide iterates
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    zf_n = zf;
    if (abort) begin
      state_n = MC_IDLE;
      cnt_n = '0;
      zf_n = 1'b0;
    end else if (start) begin
      state_n = (ex_mc_kind == MC_MADD || ex_div_zero) ? MC_DONE : MC_RUN;
      cnt_n = '0;
      zf_n = ex_mc_kind == MC_DIV && ex_div_zero;
    end else if (state == MC_RUN) begin
      state_n = last ? MC_DONE : MC_RUN;
      cnt_n = cnt + 1'b1;
    end else if (state == MC_DONE) begin
      state_n = MC_IDLE;
      cnt_n = '0;
      zf_n = 1'b0;
    end
  end
  // fixed-priority stall encoder: EX multi-cycle over ID load-use over IF fetch wait
  always_comb begin
    stall = rst ? STALL_NONE : ex_mc_stall ? STALL_EX : stallreq_id ? STALL_ID : stallreq_if ? STALL_IF : STALL_NONE;
  end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed and randomized self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;
  localparam int DIV_CYCLES = 32;
  localparam int CNT_W = 6;
  logic clk = 0;
  logic rst = 1;
  logic stallreq_if = 0, stallreq_id = 0, ex_mc_req = 0, ex_div_zero = 0, ex_mc_annul = 0;
  logic [1:0] ex_mc_kind = 0;
  logic [5:0] stall;
  logic mc_busy, mc_first, mc_done, mc_div_zero;
  logic [CNT_W-1:0] mc_cnt;
  int tests = 0;
  int fails = 0;
  logic saw_done = 0;
  int step = 0;
  int len = 0;
  bit zf = 0;

  pipe_stall_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .ex_mc_req(ex_mc_req), .ex_mc_kind(ex_mc_kind), .ex_div_zero(ex_div_zero),
    .ex_mc_annul(ex_mc_annul), .stall(stall), .mc_busy(mc_busy), .mc_first(mc_first),
    .mc_cnt(mc_cnt), .mc_done(mc_done), .mc_div_zero(mc_div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an op is a count of cycles since it started (step);
  // step 0 = no op, step == len = result cycle, anything between = divide iteration step-1.
  always @(negedge clk) begin
    bit idle, run, done, ann, strt, exs;
    logic [5:0] e_stall;
    idle = step == 0;
    run = step > 0 && step < len;
    done = step > 0 && step == len;
    ann = ex_mc_annul || (run && !ex_mc_req);
    strt = idle && ex_mc_req && (ex_mc_kind == 2'd1 || ex_mc_kind == 2'd2) && !ex_mc_annul;
    exs = !ann && (strt || run);
    e_stall = exs ? 6'b001111 : stallreq_id ? 6'b000111 : stallreq_if ? 6'b000011 : 6'b000000;
    if (rst) begin
      check("m_stall", 32'(stall), 0);
      check("m_busy", 32'(mc_busy), 0);
      check("m_first", 32'(mc_first), 0);
      check("m_done", 32'(mc_done), 0);
      check("m_dz", 32'(mc_div_zero), 0);
      check("m_cnt", 32'(mc_cnt), 0);
      step = 0;
    end else begin
      check("m_stall", 32'(stall), 32'(e_stall));
      check("m_busy", 32'(mc_busy), 32'(!idle));
      check("m_first", 32'(mc_first), 32'(strt && ex_mc_kind == 2'd1));
      check("m_done", 32'(mc_done), 32'(done && !ex_mc_annul));
      check("m_dz", 32'(mc_div_zero), 32'(done && !ex_mc_annul && zf));
      if (!done) check("m_cnt", 32'(mc_cnt), run ? 32'(step - 1) : 0);
      if (ann) step = 0;
      else if (strt) begin
        step = 1;
        zf = ex_mc_kind == 2'd2 && ex_div_zero;
        len = (ex_mc_kind == 2'd1 || ex_div_zero) ? 1 : DIV_CYCLES + 1;
      end else if (step > 0) step = (step == len) ? 0 : step + 1;
    end
    saw_done = mc_done;
  end

  initial begin
    int n, cnt_bad, found, dones;
    tick();
    tick();
    stallreq_if = 1; stallreq_id = 1; ex_mc_req = 1; ex_mc_kind = 2'd2;
    @(negedge clk); #1;
    check("rst_stall", 32'(stall), 32'(6'b000000));
    check("rst_busy", 32'(mc_busy), 0);
    tick();
    rst = 0; stallreq_id = 0; ex_mc_req = 0; ex_mc_kind = 0;
    @(negedge clk); #1;
    check("if_only", 32'(stall), 32'(6'b000011));
    tick();
    stallreq_id = 1;
    @(negedge clk); #1;
    check("if_id", 32'(stall), 32'(6'b000111));
    tick();
    ex_mc_req = 1; ex_mc_kind = 2'd1;
    @(negedge clk); #1;
    check("madd_stall", 32'(stall), 32'(6'b001111));
    check("madd_first", 32'(mc_first), 1);
    tick();
    @(negedge clk); #1;
    check("madd_done", 32'(mc_done), 1);
    check("madd_stall2", 32'(stall), 32'(6'b000111));
    check("madd_first2", 32'(mc_first), 0);
    tick();
    ex_mc_req = 0; ex_mc_kind = 0; stallreq_if = 0; stallreq_id = 0;
    @(negedge clk); #1;
    check("idle_stall", 32'(stall), 0);
    tick();
    ex_mc_req = 1; ex_mc_kind = 2'd2;
    n = 0; cnt_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (stall != 6'b001111) break;
      n++;
      if (n > 1 && int'(mc_cnt) != n - 2) cnt_bad++;
    end
    check("div_stall_cycles", 32'(n), 33);
    check("div_cnt_seq", 32'(cnt_bad), 0);
    check("div_done", 32'(mc_done), 1);
    check("div_dz", 32'(mc_div_zero), 0);
    tick();
    ex_mc_req = 0; ex_mc_kind = 0;
    tick();
    ex_mc_req = 1; ex_mc_kind = 2'd2; ex_div_zero = 1;
    @(negedge clk); #1;
    check("dz_stall", 32'(stall), 32'(6'b001111));
    tick();
    @(negedge clk); #1;
    check("dz_done", 32'(mc_done), 1);
    check("dz_flag", 32'(mc_div_zero), 1);
    check("dz_stall2", 32'(stall), 0);
    tick();
    ex_mc_req = 0; ex_mc_kind = 0; ex_div_zero = 0;
    tick();
    ex_mc_req = 1; ex_mc_kind = 2'd2;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk); #1;
      if (mc_busy && mc_cnt == 9) found = 1;
    end
    check("annul_reach9", 32'(found), 1);
    tick();
    ex_mc_annul = 1;
    @(negedge clk); #1;
    check("annul_cnt10", 32'(mc_cnt), 10);
    check("annul_stall", 32'(stall), 0);
    check("annul_nodone", 32'(mc_done), 0);
    tick();
    ex_mc_annul = 0; ex_mc_req = 0; ex_mc_kind = 0;
    @(negedge clk); #1;
    check("annul_idle", 32'(mc_busy), 0);
    check("annul_cnt0", 32'(mc_cnt), 0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (mc_done) dones++;
    end
    check("annul_no_done", 32'(dones), 0);
    tick();
    ex_mc_req = 1; ex_mc_kind = 2'd2;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk); #1;
      if (mc_busy && mc_cnt == 4) found = 1;
    end
    check("rst_reach4", 32'(found), 1);
    tick();
    rst = 1;
    @(negedge clk); #1;
    check("rstmid_stall", 32'(stall), 0);
    check("rstmid_busy", 32'(mc_busy), 0);
    tick();
    rst = 0;
    @(negedge clk); #1;
    check("restart_idle", 32'(mc_busy), 0);
    check("restart_cnt", 32'(mc_cnt), 0);
    check("restart_stall", 32'(stall), 32'(6'b001111));
    tick();
    @(negedge clk); #1;
    check("restart_run", 32'(mc_busy), 1);
    check("restart_cnt_run", 32'(mc_cnt), 0);
    tick();
    ex_mc_req = 0; ex_mc_kind = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom % 150) == 0;
      stallreq_if = ($urandom % 4) == 0;
      stallreq_id = ($urandom % 4) == 0;
      ex_mc_annul = ($urandom % 40) == 0;
      if (ex_mc_req) begin
        if (saw_done || ($urandom % 60) == 0 || (ex_mc_kind != 2'd1 && ex_mc_kind != 2'd2 && ($urandom % 4) == 0))
          ex_mc_req = 0;
      end else if (($urandom % 5) == 0) begin
        ex_mc_req = 1;
        ex_mc_kind = 2'($urandom_range(0, 3));
        ex_div_zero = ($urandom % 3) == 0;
      end
    end
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
